// File: rtl/mem_lat_32.sv
// Parametrised-latency byte-addressable 32-bit data memory with valid/ready handshake.
// Define MEM_MISALIGN_TRAP_EN to fault on misaligned half/word accesses instead of performing them bytewise.
package mem_defs;
  typedef enum logic [1:0] {
    LEN_BYTE    = 2'd0,
    LEN_HALF    = 2'd1,
    LEN_WORD    = 2'd2,
    LEN_INVALID = 2'd3
  } data_length_t;

  typedef enum logic {
    SIG   = 1'b0,
    UNSIG = 1'b1
  } unsigned_t;
endpackage

// state | meaning
// IDLE  | ready for a request
// WAIT  | latency countdown, request held in capture registers
// RESP  | response presented until consumer accepts it
module mem_lat_32 #(
  parameter int SIZE      = 1024,
  parameter int ADDR_BITS = $clog2(SIZE),
  parameter int LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_wr,
  input  logic [ADDR_BITS-1:0]    req_addr,
  input  logic [31:0]             req_data,
  input  mem_defs::data_length_t  req_len,
  input  mem_defs::unsigned_t     req_sign,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_data,
  output logic                    resp_fault
);
  import mem_defs::*;

  localparam int EW = ADDR_BITS + 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   capture;
  logic                   enter_resp;

  logic                   q_wr;
  logic [ADDR_BITS-1:0]   q_addr;
  logic [31:0]            q_data;
  data_length_t           q_len;
  unsigned_t              q_sign;

  logic                   a_wr;
  logic [ADDR_BITS-1:0]   a_addr;
  logic [31:0]            a_data;
  data_length_t           a_len;
  unsigned_t              a_sign;

  logic [2:0]             nbytes;
  logic [EW-1:0]          baddr [4];
  logic [7:0]             rbyte [4];
  logic [EW-1:0]          last_addr;
  logic                   misalign;
  logic                   fault;
  logic                   ext;
  logic [31:0]            ld_data;

  logic [31:0]            resp_data_q;
  logic                   resp_fault_q;

  logic [7:0]             mem [SIZE];

  // With LATENCY=1 the access runs on the accept edge, before the capture registers load.
  always_comb begin
    if (state_q == IDLE) begin
      a_wr   = req_wr;
      a_addr = req_addr;
      a_data = req_data;
      a_len  = req_len;
      a_sign = req_sign;
    end else begin
      a_wr   = q_wr;
      a_addr = q_addr;
      a_data = q_data;
      a_len  = q_len;
      a_sign = q_sign;
    end
  end

  always_comb begin
    nbytes = 3'd1;
    case (a_len)
      LEN_BYTE: nbytes = 3'd1;
      LEN_HALF: nbytes = 3'd2;
      LEN_WORD: nbytes = 3'd4;
      default:  nbytes = 3'd1;
    endcase
    for (int i = 0; i < 4; i++) begin
      baddr[i] = EW'(a_addr) + EW'(i);
      rbyte[i] = (baddr[i] < EW'(SIZE)) ? mem[baddr[i][ADDR_BITS-1:0]] : 8'h00;
    end
    last_addr = EW'(a_addr) + EW'(nbytes) - EW'(1);
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = ((a_len == LEN_HALF) && a_addr[0]) ||
               ((a_len == LEN_WORD) && (a_addr[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    fault = (a_len == LEN_INVALID) || (last_addr >= EW'(SIZE)) || misalign;
    ext   = (a_sign == SIG);
    case (a_len)
      LEN_BYTE: ld_data = {{24{ext & rbyte[0][7]}}, rbyte[0]};
      LEN_HALF: ld_data = {{16{ext & rbyte[1][7]}}, rbyte[1], rbyte[0]};
      LEN_WORD: ld_data = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};
      default:  ld_data = 32'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = 8'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 8'd1;
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    enter_resp = (state_d == RESP) && (state_q != RESP);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      q_wr         <= 1'b0;
      q_addr       <= '0;
      q_data       <= 32'h0;
      q_len        <= LEN_BYTE;
      q_sign       <= SIG;
      resp_data_q  <= 32'h0;
      resp_fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) begin
        q_wr   <= req_wr;
        q_addr <= req_addr;
        q_data <= req_data;
        q_len  <= req_len;
        q_sign <= req_sign;
      end
      if (enter_resp) begin
        resp_data_q  <= (fault || a_wr) ? 32'h0 : ld_data;
        resp_fault_q <= fault;
      end else if ((state_q == RESP) && resp_ready) begin
        resp_data_q  <= 32'h0;
        resp_fault_q <= 1'b0;
      end
    end
  end

  // Array has no reset so contents survive it; the reset gate stops a write while reset is held.
  always_ff @(posedge clk) begin
    if (enter_resp && a_wr && !fault && !reset) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) < nbytes) mem[baddr[i][ADDR_BITS-1:0]] <= a_data[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mem_lat_32.sv
// Scoreboard bench for mem_lat_32: LATENCY=4 instance for function/timing, LATENCY=1 instance for issue rate.
module tb_mem_lat_32;
  import mem_defs::*;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         req_valid, req_ready, req_wr;
  logic [9:0]   req_addr;
  logic [31:0]  req_data;
  data_length_t req_len;
  unsigned_t    req_sign;
  logic         resp_valid, resp_ready, resp_fault;
  logic [31:0]  resp_data;

  logic         req_valid1, req_ready1, req_wr1;
  logic [9:0]   req_addr1;
  logic [31:0]  req_data1;
  data_length_t req_len1;
  unsigned_t    req_sign1;
  logic         resp_valid1, resp_ready1, resp_fault1;
  logic [31:0]  resp_data1;

  mem_lat_32 #(.SIZE(1024), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .req_len(req_len), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_fault(resp_fault)
  );

  mem_lat_32 #(.SIZE(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wr(req_wr1),
    .req_addr(req_addr1), .req_data(req_data1), .req_len(req_len1), .req_sign(req_sign1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_data(resp_data1), .resp_fault(resp_fault1)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        fault;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got_data, input logic got_fault);
    exp_t e;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"}, got_data, e.data);
      check({tag, "_fault"}, 32'(got_fault), 32'(e.fault));
    end
  endtask

  // Issue one request on the LATENCY=4 instance and retire its response.
  task automatic issue(input string tag, input logic wr, input logic [9:0] addr,
                       input logic [31:0] data, input data_length_t len, input unsigned_t sign,
                       input logic [31:0] exp_data, input logic exp_fault, input int hold);
    int n;
    exp_q.push_back('{data: exp_data, fault: exp_fault});
    resp_ready = (hold == 0);
    req_valid  = 1'b1;
    req_wr     = wr;
    req_addr   = addr;
    req_data   = data;
    req_len    = len;
    req_sign   = sign;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready_wait"}, 32'(n < 20), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_wr    = 1'($urandom);
    req_addr  = 10'($urandom);
    req_data  = $urandom;
    req_len   = data_length_t'(2'($urandom));
    check({tag, "_busy"}, 32'(req_ready), 32'd0);
    n = 0;
    while (!resp_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_latency"}, 32'(n), 32'(LAT));
    pop_check(tag, resp_data, resp_fault);
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
      check({tag, "_hold_data"}, resp_data, exp_data);
      check({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_one_cycle"}, 32'(resp_valid), 32'd0);
    check({tag, "_ready_after_hs"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int n, cyc, last_acc;
    logic [31:0] d1 [6];

    req_valid = 0; req_wr = 0; req_addr = '0; req_data = '0; req_len = LEN_WORD; req_sign = SIG;
    resp_ready = 1;
    req_valid1 = 0; req_wr1 = 0; req_addr1 = '0; req_data1 = '0; req_len1 = LEN_WORD; req_sign1 = SIG;
    resp_ready1 = 1;

    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'h0);
    check("rst_resp_fault", 32'(resp_fault), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // LATENCY=1: requests held valid back to back, accepted every second edge.
    for (int k = 0; k < 6; k++) d1[k] = 32'h1357_0000 | 32'(k * 32'h0101);
    cyc = 0;
    last_acc = 0;
    req_valid1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      req_wr1   = (k % 2 == 0);
      req_addr1 = 10'(32'h40 + 4 * (k / 2));
      req_data1 = d1[k];
      req_len1  = LEN_WORD;
      if (k % 2 == 0) exp_q.push_back('{data: 32'h0, fault: 1'b0});
      else            exp_q.push_back('{data: d1[k-1], fault: 1'b0});
      n = 0;
      while (!req_ready1 && n < 10) begin
        @(posedge clk); #1; cyc++; n++;
      end
      check("lat1_ready_wait", 32'(n < 10), 32'd1);
      @(posedge clk); #1; cyc++;
      if (k > 0) check("lat1_interval", 32'(cyc - last_acc), 32'd2);
      last_acc = cyc;
      check("lat1_resp_valid", 32'(resp_valid1), 32'd1);
      pop_check("lat1", resp_data1, resp_fault1);
    end
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    check("lat1_done_idle", 32'(resp_valid1), 32'd0);

    // LATENCY=4 functional sequence.
    issue("st_w10",   1, 10'h010, 32'hDEADBEEF, LEN_WORD, SIG,   32'h0,        1'b0, 0);
    issue("ld_w10",   0, 10'h010, 32'h0,        LEN_WORD, UNSIG, 32'hDEADBEEF, 1'b0, 0);
    issue("ld_b13s",  0, 10'h013, 32'h0,        LEN_BYTE, SIG,   32'hFFFFFFDE, 1'b0, 0);
    issue("ld_b13u",  0, 10'h013, 32'h0,        LEN_BYTE, UNSIG, 32'h000000DE, 1'b0, 0);
    issue("ld_h12s",  0, 10'h012, 32'h0,        LEN_HALF, SIG,   32'hFFFFDEAD, 1'b0, 0);
    issue("ld_h12u",  0, 10'h012, 32'h0,        LEN_HALF, UNSIG, 32'h0000DEAD, 1'b0, 0);
    issue("ld_b10s",  0, 10'h010, 32'h0,        LEN_BYTE, SIG,   32'hFFFFFFEF, 1'b0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    issue("st_h11",   1, 10'h011, 32'h00001234, LEN_HALF, SIG,   32'h0,        1'b1, 0);
    issue("ld_w10b",  0, 10'h010, 32'h0,        LEN_WORD, SIG,   32'hDEADBEEF, 1'b0, 0);
`else
    issue("st_h11",   1, 10'h011, 32'h00001234, LEN_HALF, SIG,   32'h0,        1'b0, 0);
    issue("ld_w10b",  0, 10'h010, 32'h0,        LEN_WORD, SIG,   32'hDE1234EF, 1'b0, 0);
`endif
    issue("ld_w3fe",  0, 10'h3FE, 32'h0,        LEN_WORD, SIG,   32'h0,        1'b1, 0);
    issue("len_inv",  0, 10'h010, 32'h0,        LEN_INVALID, SIG, 32'h0,       1'b1, 0);
    issue("st_b3ff",  1, 10'h3FF, 32'h0000007F, LEN_BYTE, SIG,   32'h0,        1'b0, 0);
    issue("ld_b3ff",  0, 10'h3FF, 32'h0,        LEN_BYTE, SIG,   32'h0000007F, 1'b0, 0);
    issue("ld_hold",  0, 10'h013, 32'h0,        LEN_BYTE, UNSIG, 32'h000000DE, 1'b0, 3);
    issue("st_w20",   1, 10'h020, 32'h01020304, LEN_WORD, SIG,   32'h0,        1'b0, 0);

    // Reset two cycles into a store: no write, outputs drop at once.
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h020; req_data = 32'h55AA55AA;
    req_len = LEN_WORD; req_sign = SIG;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rst_mid_busy", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_mid_req_ready", 32'(req_ready), 32'd1);
    check("rst_mid_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mid_resp_data", resp_data, 32'h0);
    check("rst_mid_resp_fault", 32'(resp_fault), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    issue("ld_w20",   0, 10'h020, 32'h0,        LEN_WORD, SIG,   32'h01020304, 1'b0, 0);
    issue("ld_w10c",  0, 10'h3FF, 32'h0,        LEN_BYTE, UNSIG, 32'h0000007F, 1'b0, 0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
